// File: rtl/alu_sequencer.sv
// Purpose : owns the shared combinational ALU; runs single-pass ops and iterates it for multi-bit SHR and 32/32 unsigned divide.
// Latency : 2 cycles single-pass / shift 0-1 / divide-by-zero, n+1 cycles shift by n>=2, 33 cycles divide (accept edge to done).
// Backpressure: one op in flight; start is sampled only while busy=0 and is dropped, not queued, otherwise.
// Ports   : clk, reset (sync, active-high); request start/op/a/b/carry_in; status busy/done;
//           registered result c with carry_out/is_zero/is_negative; ALU side alu_a/alu_b/alu_carry_in/alu_op out, alu_c/alu_carry_out in.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] c,
  output logic        carry_out,
  output logic        is_zero,
  output logic        is_negative,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_carry_in,
  output logic [7:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_carry_out
);

  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SHR  = 5'd13;
  localparam logic [4:0] OP_DIVQ = 5'd20;
  localparam logic [4:0] OP_DIVR = 5'd21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_DIV,
    S_FIN
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] a_q, b_q;
  logic        cin_q;
  logic [4:0]  op_q;
  logic [5:0]  cnt;
  // Shift working value, or the quotient/dividend register while dividing.
  logic [31:0] work;
  // Restoring-divide remainder. Its 33rd bit is always 0 between iterations
  // (it is only set when the trial subtract succeeds, which clears it), so
  // only 32 bits are stored.
  logic [31:0] rem;

  logic        accept;
  logic        load_res;
  logic [31:0] res_nxt;
  logic        cry_nxt;
  logic [32:0] r_sh;
  logic        div_ge;
  logic [31:0] q_nxt;
  logic [31:0] r_nxt;

  logic        unused_op_hi;
  assign unused_op_hi = &{1'b0, op[7:5]};

  // Next state, ALU drive and result selection.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    load_res     = 1'b0;
    res_nxt      = 32'd0;
    cry_nxt      = 1'b0;
    alu_a        = 32'd0;
    alu_b        = 32'd0;
    alu_carry_in = 1'b0;
    alu_op       = 8'd0;

    r_sh   = {rem, work[31]};
    div_ge = r_sh[32] | (r_sh[31:0] >= b_q);
    q_nxt  = {work[30:0], div_ge};
    r_nxt  = div_ge ? alu_c : r_sh[31:0];

    case (state)
      // FIN doubles as an accept slot so single-pass ops can issue every 2 cycles.
      S_IDLE, S_FIN: begin
        state_nxt = S_IDLE;
        if (start) begin
          accept = 1'b1;
          if (op[4:0] == OP_SHR && b[4:0] >= 5'd2) begin
            state_nxt = S_SHIFT;
          end else if ((op[4:0] == OP_DIVQ || op[4:0] == OP_DIVR) && b != 32'd0) begin
            state_nxt = S_DIV;
          end else begin
            state_nxt = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        state_nxt = S_FIN;
        load_res  = 1'b1;
        if (op_q == OP_SHR && b_q[4:0] == 5'd0) begin
          res_nxt = a_q;
          cry_nxt = 1'b0;
        end else if (op_q == OP_DIVQ || op_q == OP_DIVR) begin
          // Divides only reach EXEC with a zero divisor.
          res_nxt = (op_q == OP_DIVQ) ? 32'hFFFF_FFFF : a_q;
          cry_nxt = 1'b1;
        end else begin
          alu_a        = a_q;
          alu_b        = b_q;
          alu_carry_in = cin_q;
          alu_op       = {3'b000, op_q};
          res_nxt      = alu_c;
          cry_nxt      = alu_carry_out;
        end
      end

      S_SHIFT: begin
        alu_a  = work;
        alu_op = {3'b000, OP_SHR};
        if (cnt == 6'd1) begin
          state_nxt = S_FIN;
          load_res  = 1'b1;
          res_nxt   = alu_c;
          cry_nxt   = alu_carry_out;
        end
      end

      S_DIV: begin
        alu_a  = r_sh[31:0];
        alu_b  = b_q;
        alu_op = {3'b000, OP_SUB};
        if (cnt == 6'd1) begin
          state_nxt = S_FIN;
          load_res  = 1'b1;
          res_nxt   = (op_q == OP_DIVQ) ? q_nxt : r_nxt;
          cry_nxt   = 1'b0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      cin_q       <= 1'b0;
      op_q        <= 5'd0;
      cnt         <= 6'd0;
      work        <= 32'd0;
      rem         <= 32'd0;
      c           <= 32'd0;
      carry_out   <= 1'b0;
      is_zero     <= 1'b0;
      is_negative <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= carry_in;
        op_q  <= op[4:0];
        cnt   <= (op[4:0] == OP_SHR) ? {1'b0, b[4:0]} : 6'd32;
        work  <= a;
        rem   <= 32'd0;
      end else if (state == S_SHIFT) begin
        work <= alu_c;
        cnt  <= cnt - 6'd1;
      end else if (state == S_DIV) begin
        work <= q_nxt;
        rem  <= r_nxt;
        cnt  <= cnt - 6'd1;
      end

      if (load_res) begin
        c           <= res_nxt;
        carry_out   <= cry_nxt;
        is_zero     <= (res_nxt == 32'd0);
        is_negative <= res_nxt[31];
      end
    end
  end

  assign busy = (state == S_EXEC) || (state == S_SHIFT) || (state == S_DIV);
  assign done = (state == S_FIN);

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose : directed self-checking bench for alu_sequencer with a small behavioural ALU on its ALU port.
// Latency : expected latencies are counted in cycles from the accepting edge to the done cycle.
// Backpressure: checks that start during busy is dropped and that FIN-cycle starts are accepted.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  op;
  logic [31:0] a, b;
  logic        carry_in;
  logic        busy, done;
  logic [31:0] c;
  logic        carry_out, is_zero, is_negative;
  logic [31:0] alu_a, alu_b;
  logic        alu_carry_in;
  logic [7:0]  alu_op;
  logic [31:0] alu_c;
  logic        alu_carry_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .carry_in     (carry_in),
    .busy         (busy),
    .done         (done),
    .c            (c),
    .carry_out    (carry_out),
    .is_zero      (is_zero),
    .is_negative  (is_negative),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_carry_in (alu_carry_in),
    .alu_op       (alu_op),
    .alu_c        (alu_c),
    .alu_carry_out(alu_carry_out)
  );

  // Behavioural ALU: 1 add-with-carry, 2 subtract, 13 logical shift right by 1,
  // 16 AND; anything else (including nonzero op[7:5]) returns 0.
  always_comb begin
    alu_c         = 32'd0;
    alu_carry_out = 1'b0;
    case (alu_op)
      8'd1:  {alu_carry_out, alu_c} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry_in};
      8'd2:  {alu_carry_out, alu_c} = {1'b0, alu_a} - {1'b0, alu_b};
      8'd13: begin
        alu_c         = alu_a >> 1;
        alu_carry_out = alu_a[0];
      end
      8'd16: alu_c = alu_a & alu_b;
      default: begin
        alu_c         = 32'd0;
        alu_carry_out = 1'b0;
      end
    endcase
  end

  // Called at a negedge. Presents the request for one edge, scrambles the
  // operands afterwards, and returns at the negedge of the done cycle.
  task automatic do_op(input logic [7:0] o, input logic [31:0] oa, input logic [31:0] ob,
                       input logic ocin, output int lat, output int busy_cyc);
    start    = 1'b1;
    op       = o;
    a        = oa;
    b        = ob;
    carry_in = ocin;
    @(negedge clk);
    start    = 1'b0;
    op       = 8'h00;
    a        = ~oa;
    b        = ~ob;
    carry_in = ~ocin;
    lat      = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 8'd0; a = 32'd0; b = 32'd0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, carry_out, is_zero, is_negative} !== 5'b0) begin
      fails++;
      $display("FAIL reset_status: busy,done,cy,z,n=%b required 00000", {busy, done, carry_out, is_zero, is_negative});
    end
    tests++;
    if (c !== 32'd0) begin
      fails++;
      $display("FAIL reset_c: got %h required 0", c);
    end
    tests++;
    if ({alu_a, alu_b, alu_carry_in, alu_op} !== 73'd0) begin
      fails++;
      $display("FAIL reset_alu: alu_a=%h alu_b=%h cin=%b op=%h required all 0", alu_a, alu_b, alu_carry_in, alu_op);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pass();
    int lat, bc;
    do_op(8'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, bc);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL op0_latency: got %0d required 2", lat); end
    tests++;
    if (c !== 32'd0 || is_zero !== 1'b1 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL op0_result: c=%h z=%b cy=%b required 0 1 0", c, is_zero, carry_out);
    end
    tests++;
    if (bc !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL op0_busy: busy cycles=%0d busy_at_done=%b required 1 0", bc, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || c !== 32'd0) begin
      fails++;
      $display("FAIL done_pulse: done=%b c=%h a cycle later, required 0 0", done, c);
    end
    // Add with carry: carry_in must come from the accepting edge, not later.
    do_op(8'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'd0 || carry_out !== 1'b1 || is_zero !== 1'b1) begin
      fails++;
      $display("FAIL add_carry: lat=%0d c=%h cy=%b z=%b required 2 0 1 1", lat, c, carry_out, is_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_shift();
    int lat, bc;
    // op[7:5] set: must be ignored.
    do_op(8'hED, 32'h8000_0003, 32'd2, 1'b0, lat, bc);
    tests++;
    if (lat !== 3 || c !== 32'h2000_0000 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL shr2: lat=%0d c=%h cy=%b required 3 20000000 1", lat, c, carry_out);
    end
    tests++;
    if (bc !== 2) begin fails++; $display("FAIL shr2_busy: got %0d busy cycles required 2", bc); end
    do_op(8'd13, 32'h8000_0003, 32'd0, 1'b0, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'h8000_0003 || carry_out !== 1'b0 || is_negative !== 1'b1) begin
      fails++;
      $display("FAIL shr0: lat=%0d c=%h cy=%b n=%b required 2 80000003 0 1", lat, c, carry_out, is_negative);
    end
    do_op(8'd13, 32'h8000_0003, 32'd1, 1'b0, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'h4000_0001 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL shr1: lat=%0d c=%h cy=%b required 2 40000001 1", lat, c, carry_out);
    end
    do_op(8'd13, 32'h8000_0003, 32'd31, 1'b0, lat, bc);
    tests++;
    if (lat !== 32 || c !== 32'h0000_0001 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL shr31: lat=%0d c=%h cy=%b required 32 00000001 0", lat, c, carry_out);
    end
    // Only b[4:0] is the count: 34 shifts by 2.
    do_op(8'd13, 32'hF000_000F, 32'd34, 1'b0, lat, bc);
    tests++;
    if (lat !== 3 || c !== 32'h3C00_0003 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL shr_b34: lat=%0d c=%h cy=%b required 3 3c000003 1", lat, c, carry_out);
    end
    @(negedge clk);
  endtask

  task automatic test_divide();
    int lat, bc;
    do_op(8'd20, 32'd100, 32'd7, 1'b0, lat, bc);
    tests++;
    if (lat !== 33 || c !== 32'd14 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL div_q: lat=%0d c=%0d cy=%b required 33 14 0", lat, c, carry_out);
    end
    do_op(8'd21, 32'd100, 32'd7, 1'b1, lat, bc);
    tests++;
    if (lat !== 33 || c !== 32'd2) begin
      fails++;
      $display("FAIL div_r: lat=%0d c=%0d required 33 2", lat, c);
    end
    do_op(8'd20, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, lat, bc);
    tests++;
    if (c !== 32'd1 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL div_big_q: c=%h cy=%b required 00000001 0", c, carry_out);
    end
    do_op(8'd21, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, lat, bc);
    tests++;
    if (c !== 32'h7FFF_FFFF || is_negative !== 1'b0) begin
      fails++;
      $display("FAIL div_big_r: c=%h n=%b required 7fffffff 0", c, is_negative);
    end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    do_op(8'd21, 32'd5, 32'd0, 1'b0, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'd5 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL divz_r: lat=%0d c=%h cy=%b required 2 00000005 1", lat, c, carry_out);
    end
    do_op(8'd20, 32'd5, 32'd0, 1'b0, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'hFFFF_FFFF || is_negative !== 1'b1 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL divz_q: lat=%0d c=%h n=%b cy=%b required 2 ffffffff 1 1", lat, c, is_negative, carry_out);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int cyc;
    start = 1'b1; op = 8'd20; a = 32'd100; b = 32'd7; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 10) begin
        start = 1'b1; op = 8'd0; a = 32'hFFFF_FFFF; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (cyc !== 33 || c !== 32'd14) begin
      fails++;
      $display("FAIL ignored_start: lat=%0d c=%0d required 33 14", cyc, c);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL not_queued: done=%b busy=%b after finish, required 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, seen, lat, bc;
    seen = 0;
    start = 1'b1; op = 8'd21; a = 32'd100; b = 32'd7; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 20; cyc++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, carry_out, is_zero, is_negative} !== 5'b0 || c !== 32'd0) begin
      fails++;
      $display("FAIL abort_outputs: busy,done,cy,z,n=%b c=%h required 00000 0",
               {busy, done, carry_out, is_zero, is_negative}, c);
    end
    tests++;
    if ({alu_a, alu_b, alu_carry_in, alu_op} !== 73'd0 || seen != 0) begin
      fails++;
      $display("FAIL abort_alu: alu_a=%h alu_b=%h op=%h early_done=%0d required 0 0 0 0", alu_a, alu_b, alu_op, seen);
    end
    // Release reset and request on the very next edge.
    reset = 1'b0;
    do_op(8'd16, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'hF000_F000) begin
      fails++;
      $display("FAIL post_reset_accept: lat=%0d c=%h required 2 f000f000", lat, c);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0 || c !== 32'hF000_F000) begin
      fails++;
      $display("FAIL aborted_done: %0d stray done cycles, c=%h required 0 f000f000", seen, c);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(8'd1, 32'd5, 32'd7, 1'b1, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'd13 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL b2b_add: lat=%0d c=%0d cy=%b required 2 13 0", lat, c, carry_out);
    end
    // Issued during the done cycle of the previous op.
    do_op(8'd16, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'hF000_F000 || is_negative !== 1'b1 || is_zero !== 1'b0) begin
      fails++;
      $display("FAIL b2b_and: lat=%0d c=%h n=%b z=%b required 2 f000f000 1 0", lat, c, is_negative, is_zero);
    end
    do_op(8'd19, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, lat, bc);
    tests++;
    if (lat !== 2 || c !== 32'd0 || is_zero !== 1'b1 || is_negative !== 1'b0) begin
      fails++;
      $display("FAIL b2b_op19: lat=%0d c=%h z=%b n=%b required 2 0 1 0", lat, c, is_zero, is_negative);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (c !== 32'd0 || is_zero !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL hold: c=%h z=%b done=%b required 0 1 0", c, is_zero, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_shift();
    test_divide();
    test_div_by_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle sequencer that owns the shared 32-bit combinational ALU. It accepts one operation at a time from the CPU execute stage and drives the ALU directly for single-pass operations. It iterates the ALU for multi-bit logical right shifts and unsigned 32/32 division, then presents a registered result with flags and a one-cycle `done` pulse.

## Interface
- No parameters.
- `clk` in 1: system clock. One clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start` in 1: request strobe; sampled only while `busy`=0.
- `op` in 8: operation; only `op[4:0]` is decoded, `op[7:5]` is ignored.
- `a`, `b` in 32 each: operands; captured on the accepting edge.
- `carry_in` in 1: captured on the accepting edge and used by ops 1 and 3.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; result valid.
- `c` out 32: registered result.
- `carry_out`, `is_zero`, `is_negative` out 1 each: registered flags for `c`.
- `alu_a`, `alu_b` out 32 each: to the ALU `a` and `b` inputs.
- `alu_carry_in` out 1: to the ALU carry input.
- `alu_op` out 8: to the ALU `op` input; `op[7:5]` is driven 0.
- `alu_c` in 32 and `alu_carry_out` in 1: ALU result and carry.

## Operation
- States: IDLE, EXEC, SHIFT, DIV, FIN.
- **IDLE**: `alu_op`/`alu_a`/`alu_b`/`alu_carry_in` driven 0. On `start`=1, latch `a`, `b`, `carry_in` and `op[4:0]`, then branch:
  - op 13 with `b[4:0]`≥2 → SHIFT, counter = `b[4:0]`.
  - op 20/21 with `b`≠0 → DIV, counter = 32; remainder R = 0 (33 bits); quotient Q = `a`.
  - Everything else → EXEC.
- **EXEC** (one cycle): ALU gets the latched `a`, `b`, `carry_in` and op, with these special cases:
  - op 13 with shift count 0: result = `a`, carry 0, and the ALU is not used.
  - op 13 with shift count 1: a single ALU op 13.
  - op 20/21 with `b`=0: quotient = 0xFFFF_FFFF, remainder = `a`, carry_out = 1.
  - All other ops pass straight to the ALU. Ops the ALU does not implement return 0 from the ALU and complete normally.
  - Next state FIN.
- **SHIFT**: each cycle, ALU op 13 runs with `alu_a` = working register. The working register takes `alu_c`, the carry register takes `alu_carry_out`, and the counter decrements. When the counter reaches 0 → FIN.
  - Result: `a` >> n, logical; carry_out = the last bit shifted out, `a[n-1]`.
- **DIV** (restoring algorithm), per cycle:
  - R' = {R[31:0], Q[31]}.
  - ALU op 2 computes `alu_c` = R'[31:0] − `b`.
  - If R'[32]=1 or R'[31:0] ≥ `b` (unsigned, local comparator): R = {0, `alu_c`} and Q = {Q[30:0], 1'b1}. Otherwise R = R' and Q = {Q[30:0], 1'b0}.
  - After 32 iterations → FIN.
  - Op 20 returns Q; op 21 returns R[31:0]; carry_out = 0.
- **FIN**: registers `c` and `carry_out`, then returns to IDLE. `is_zero` = (`c`==0); `is_negative` = `c[31]`.
- Outputs hold their last value until the next FIN.
- `start` while `busy`=1 is ignored and not queued.
- Operands on `a`/`b`/`carry_in` may change freely after the accepting edge.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `c`=0, `carry_out`=0, `is_zero`=0, `is_negative`=0; all `alu_*` outputs 0.
- `reset` mid-operation aborts it: no `done`, the outputs take their reset values, and the next edge after `reset` falls can accept `start`.
- `busy` is 1 from the cycle after the accepting edge until the cycle in which `done`=1; during that cycle `busy`=0.
- `done` is high for exactly one cycle. A new `start` sampled in that cycle is accepted, allowing back-to-back operations every 2 cycles for single-pass ops.
- Latency from the accepting edge to the `done` cycle:
  - Single-pass, shift by 0 or 1, and divide-by-zero: 2 cycles.
  - Shift by n≥2: n+1 cycles (max 32).
  - Divide: 33 cycles.
- `alu_*` outputs are combinational from the state registers; the ALU is combinational, so each iteration closes within one cycle.

## Test plan
- Reset, then op 0 with `a`=0xFFFF_FFFF, `b`=1 → `done` at cycle 2 after accept; `c`=0, `is_zero`=1, `carry_out`=0; `busy`=1 only in cycle 1.
- Op 13 with `a`=0x8000_0003, `b`=2 → done at cycle 3; `c`=0x2000_0000, `carry_out`=1. Repeat with `b`=0 → `c`=0x8000_0003, `carry_out`=0, latency 2. Repeat with `b`=31 → `c`=1, latency 32.
- Op 20 with `a`=100, `b`=7 → done at cycle 33, `c`=14. Op 21 with the same operands → `c`=2. Op 20 with `a`=0xFFFF_FFFF, `b`=0x8000_0000 → `c`=1.
- Op 21 with `a`=5, `b`=0 → latency 2, `c`=5, `carry_out`=1. Op 20 with `a`=5, `b`=0 → `c`=0xFFFF_FFFF, `is_negative`=1.
- Divide in progress, `start` pulsed with op 0 at cycle 10 → ignored, the divide result is unchanged. Assert `reset` at cycle 20 → no `done`; all outputs 0 on the next cycle.
- Op 16 accepted in the same cycle as a previous `done` → accepted, with its own `done` 2 cycles later. Op 19 → `c`=0, `is_zero`=1.
